// File: rtl/csr_unit_if.sv
// CSR instruction bus between the decode stage and the CSR unit.
// Signal names match the original csr_unit ports so existing connections map one-to-one.
interface csr_unit_if;
  logic        i_csr_valid;
  logic [1:0]  i_csr_op;
  logic [11:0] i_csr_addr;
  logic [31:0] i_wr_data;
  logic        i_src_zero;
  logic [31:0] o_rd_data;
  logic        o_illegal;

  modport master (
    output i_csr_valid, i_csr_op, i_csr_addr, i_wr_data, i_src_zero,
    input  o_rd_data, o_illegal
  );

  modport slave (
    input  i_csr_valid, i_csr_op, i_csr_addr, i_wr_data, i_src_zero,
    output o_rd_data, o_illegal
  );
endinterface

// File: rtl/csr_unit.sv
// CSR unit: FP status (fflags/frm/fcsr), mcountinhibit and the cycle/instret counters.
// Reads return the pre-write value combinationally; writes land on the next rising edge.
module csr_unit #(
  parameter int unsigned CNT_WIDTH      = 64,
  parameter int unsigned NUM_FLAG_PORTS = 2,
  parameter int unsigned HAS_FPU        = 1
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  csr_unit_if.slave                   bus,
  input  logic [NUM_FLAG_PORTS-1:0]   i_flags_valid,
  input  logic [5*NUM_FLAG_PORTS-1:0] i_flags,
  input  logic                        i_retire,
  output logic [2:0]                  o_frm,
  output logic                        o_frm_invalid
);

  typedef enum logic [1:0] {
    OP_RO = 2'b00,
    OP_RW = 2'b01,
    OP_RS = 2'b10,
    OP_RC = 2'b11
  } csr_op_e;

  localparam logic [11:0] ADDR_FFLAGS    = 12'h001;
  localparam logic [11:0] ADDR_FRM       = 12'h002;
  localparam logic [11:0] ADDR_FCSR      = 12'h003;
  localparam logic [11:0] ADDR_MCNTINH   = 12'h320;
  localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
  localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
  localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
  localparam logic [11:0] ADDR_CYCLE     = 12'hC00;
  localparam logic [11:0] ADDR_CYCLEH    = 12'hC80;
  localparam logic [11:0] ADDR_INSTRET   = 12'hC02;
  localparam logic [11:0] ADDR_INSTRETH  = 12'hC82;

  localparam bit FPU_EN = (HAS_FPU != 0);

  logic [4:0]           fflags;
  logic [2:0]           frm;
  logic                 inh_cy;
  logic                 inh_ir;
  logic [CNT_WIDTH-1:0] mcycle;
  logic [CNT_WIDTH-1:0] minstret;

  // Counters viewed as 64 bits so high halves zero-pad for any width in 32..64.
  logic [63:0] cyc_ext;
  logic [63:0] ins_ext;
  logic [31:0] old_val;
  logic [31:0] wval;
  logic        mapped;
  logic        read_only;
  logic        wr_attempt;
  logic        bad;
  logic        do_wr;
  logic        wr_fflags, wr_frm, wr_fcsr, wr_inh;
  logic        wr_cyc_lo, wr_cyc_hi, wr_ins_lo, wr_ins_hi;
  logic [4:0]  flag_or;
  csr_op_e     op;

  assign op      = csr_op_e'(bus.i_csr_op);
  assign cyc_ext = 64'(mcycle);
  assign ins_ext = 64'(minstret);

  always_comb begin
    mapped  = 1'b1;
    old_val = '0;
    case (bus.i_csr_addr)
      ADDR_FFLAGS: begin
        mapped  = FPU_EN;
        old_val = {27'b0, fflags};
      end
      ADDR_FRM: begin
        mapped  = FPU_EN;
        old_val = {29'b0, frm};
      end
      ADDR_FCSR: begin
        mapped  = FPU_EN;
        old_val = {24'b0, frm, fflags};
      end
      ADDR_MCNTINH:                  old_val = {29'b0, inh_ir, 1'b0, inh_cy};
      ADDR_MCYCLE,   ADDR_CYCLE:     old_val = cyc_ext[31:0];
      ADDR_MCYCLEH,  ADDR_CYCLEH:    old_val = cyc_ext[63:32];
      ADDR_MINSTRET, ADDR_INSTRET:   old_val = ins_ext[31:0];
      ADDR_MINSTRETH, ADDR_INSTRETH: old_val = ins_ext[63:32];
      default:                       mapped  = 1'b0;
    endcase
  end

  always_comb begin
    read_only  = (bus.i_csr_addr == ADDR_CYCLE)   || (bus.i_csr_addr == ADDR_CYCLEH) ||
                 (bus.i_csr_addr == ADDR_INSTRET) || (bus.i_csr_addr == ADDR_INSTRETH);
    wr_attempt = (op == OP_RW) || (((op == OP_RS) || (op == OP_RC)) && !bus.i_src_zero);
    bad        = !mapped || (wr_attempt && read_only);
    do_wr      = bus.i_csr_valid && !bad && wr_attempt;
    case (op)
      OP_RW:   wval = bus.i_wr_data;
      OP_RS:   wval = old_val | bus.i_wr_data;
      OP_RC:   wval = old_val & ~bus.i_wr_data;
      default: wval = old_val;
    endcase
    wr_fflags = do_wr && (bus.i_csr_addr == ADDR_FFLAGS);
    wr_frm    = do_wr && (bus.i_csr_addr == ADDR_FRM);
    wr_fcsr   = do_wr && (bus.i_csr_addr == ADDR_FCSR);
    wr_inh    = do_wr && (bus.i_csr_addr == ADDR_MCNTINH);
    wr_cyc_lo = do_wr && (bus.i_csr_addr == ADDR_MCYCLE);
    wr_cyc_hi = do_wr && (bus.i_csr_addr == ADDR_MCYCLEH);
    wr_ins_lo = do_wr && (bus.i_csr_addr == ADDR_MINSTRET);
    wr_ins_hi = do_wr && (bus.i_csr_addr == ADDR_MINSTRETH);
  end

  always_comb begin
    flag_or = '0;
    for (int unsigned i = 0; i < NUM_FLAG_PORTS; i++) begin
      if (i_flags_valid[i]) flag_or = flag_or | i_flags[5*i +: 5];
    end
    if (!FPU_EN) flag_or = '0;
  end

  assign bus.o_rd_data = bad ? '0 : old_val;
  assign bus.o_illegal = bus.i_csr_valid && bad;
  assign o_frm         = frm;
  assign o_frm_invalid = (frm >= 3'd5);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fflags   <= '0;
      frm      <= '0;
      inh_cy   <= 1'b0;
      inh_ir   <= 1'b0;
      mcycle   <= '0;
      minstret <= '0;
    end else begin
      fflags <= ((wr_fflags || wr_fcsr) ? wval[4:0] : fflags) | flag_or;
      if (wr_frm)       frm <= wval[2:0];
      else if (wr_fcsr) frm <= wval[7:5];
      if (wr_inh) begin
        inh_cy <= wval[0];
        inh_ir <= wval[2];
      end
      // A half write replaces that cycle's increment; the other half keeps its pre-increment value.
      if (wr_cyc_lo)      mcycle <= CNT_WIDTH'({cyc_ext[63:32], wval});
      else if (wr_cyc_hi) mcycle <= CNT_WIDTH'({wval, cyc_ext[31:0]});
      else if (!inh_cy)   mcycle <= mcycle + CNT_WIDTH'(1);
      if (wr_ins_lo)                minstret <= CNT_WIDTH'({ins_ext[63:32], wval});
      else if (wr_ins_hi)           minstret <= CNT_WIDTH'({wval, ins_ext[31:0]});
      else if (i_retire && !inh_ir) minstret <= minstret + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_csr_unit.sv
// Bench for csr_unit: a 64-bit FPU build and a 40-bit no-FPU build driven through a scoreboard.
// Expected read/illegal results are queued at drive time and compared when the DUT output is sampled.
module tb_csr_unit;

  localparam logic [1:0] RO = 2'b00;
  localparam logic [1:0] RW = 2'b01;
  localparam logic [1:0] RS = 2'b10;
  localparam logic [1:0] RC = 2'b11;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  csr_unit_if bus0();
  csr_unit_if bus1();

  logic [1:0] fv0, fv1;
  logic [9:0] fl0, fl1;
  logic       retire0, retire1;
  logic [2:0] frm0, frm1;
  logic       inv0, inv1;

  csr_unit #(.CNT_WIDTH(64), .NUM_FLAG_PORTS(2), .HAS_FPU(1)) u0 (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus0.slave),
    .i_flags_valid(fv0), .i_flags(fl0), .i_retire(retire0),
    .o_frm(frm0), .o_frm_invalid(inv0)
  );

  csr_unit #(.CNT_WIDTH(40), .NUM_FLAG_PORTS(2), .HAS_FPU(0)) u1 (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus1.slave),
    .i_flags_valid(fv1), .i_flags(fl1), .i_retire(retire1),
    .o_frm(frm1), .o_frm_invalid(inv1)
  );

  typedef struct {
    string       tag;
    logic [32:0] val;
    logic [32:0] mask;
  } exp_t;

  exp_t       exp_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [1:0] pend_fv  = '0;
  logic [9:0] pend_fl  = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic xact_m(input string tag, input bit sel, input logic [1:0] op,
                        input logic [11:0] addr, input logic [31:0] wd, input logic sz,
                        input logic exp_ill, input logic [31:0] exp_rd, input logic [32:0] mask);
    exp_t        e;
    logic [32:0] got;
    @(posedge clk);
    #1;
    bus0.i_csr_valid = !sel;
    bus1.i_csr_valid = sel;
    bus0.i_csr_op = op;   bus1.i_csr_op = op;
    bus0.i_csr_addr = addr; bus1.i_csr_addr = addr;
    bus0.i_wr_data = wd;  bus1.i_wr_data = wd;
    bus0.i_src_zero = sz; bus1.i_src_zero = sz;
    fv0 = pend_fv;
    fl0 = pend_fl;
    pend_fv = '0;
    exp_q.push_back('{tag, {exp_ill, exp_rd}, mask});
    @(negedge clk);
    got = sel ? {bus1.o_illegal, bus1.o_rd_data} : {bus0.o_illegal, bus0.o_rd_data};
    e = exp_q.pop_front();
    check(e.tag, 64'(got & e.mask), 64'(e.val & e.mask));
  endtask

  task automatic xact(input string tag, input bit sel, input logic [1:0] op,
                      input logic [11:0] addr, input logic [31:0] wd, input logic sz,
                      input logic exp_ill, input logic [31:0] exp_rd);
    xact_m(tag, sel, op, addr, wd, sz, exp_ill, exp_rd, '1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, %0d checks done", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1;
    fv0 = '0; fl0 = '0; fv1 = '0; fl1 = '0;
    retire0 = 1'b0; retire1 = 1'b0;
    bus0.i_csr_valid = 1'b0; bus0.i_csr_op = RO; bus0.i_csr_addr = '0;
    bus0.i_wr_data = '0; bus0.i_src_zero = 1'b0;
    bus1.i_csr_valid = 1'b0; bus1.i_csr_op = RO; bus1.i_csr_addr = '0;
    bus1.i_wr_data = '0; bus1.i_src_zero = 1'b0;
    #1 rst_n = 1'b0;
    #1 bus0.i_csr_valid = 1'b1; bus0.i_csr_addr = 12'h003;
    #1;
    check("reset_fcsr", {31'b0, bus0.o_illegal, bus0.o_rd_data}, 64'h0);
    check("reset_frm", 64'(frm0), 64'h0);
    check("reset_frm_invalid", 64'(inv0), 64'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // fcsr write with reserved rounding mode
    xact("fcsr_rw_old", 0, RW, 12'h003, 32'hE5, 1'b0, 1'b0, 32'h0);
    xact("fcsr_read", 0, RO, 12'h003, 32'h0, 1'b0, 1'b0, 32'hE5);
    check("frm_after_fcsr", 64'(frm0), 64'h7);
    check("frm_invalid_7", 64'(inv0), 64'h1);
    xact("frm_rw_old", 0, RW, 12'h002, 32'hFD, 1'b0, 1'b0, 32'h7);
    xact("frm_read_5", 0, RO, 12'h002, 32'h0, 1'b0, 1'b0, 32'h5);
    check("frm_invalid_5", 64'(inv0), 64'h1);
    xact("frm_rw_2", 0, RW, 12'h002, 32'h2, 1'b0, 1'b0, 32'h5);
    xact("fcsr_read_45", 0, RO, 12'h003, 32'h0, 1'b0, 1'b0, 32'h45);
    check("frm_invalid_2", 64'(inv0), 64'h0);

    // sticky flag accumulation alongside a clear
    xact("fflags_rw", 0, RW, 12'h001, 32'h01, 1'b0, 1'b0, 32'h05);
    pend_fv = 2'b11; pend_fl = {5'h04, 5'h10};
    xact("fflags_rc_old", 0, RC, 12'h001, 32'h01, 1'b0, 1'b0, 32'h01);
    pend_fv = 2'b01; pend_fl = {5'h01, 5'h08};
    xact("fflags_acc", 0, RO, 12'h001, 32'h0, 1'b0, 1'b0, 32'h14);
    xact("fflags_port_mask", 0, RO, 12'h001, 32'h0, 1'b0, 1'b0, 32'h1C);
    xact("fcsr_rs_zero", 0, RS, 12'h003, 32'hFF, 1'b1, 1'b0, 32'h5C);
    xact("fcsr_unchanged", 0, RO, 12'h003, 32'h0, 1'b0, 1'b0, 32'h5C);

    // read-only counter access rules
    xact("mcntinh_rw", 0, RW, 12'h320, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h0);
    xact("mcntinh_read", 0, RO, 12'h320, 32'h0, 1'b0, 1'b0, 32'h5);
    xact_m("mcycle_set", 0, RW, 12'hB00, 32'h1234, 1'b0, 1'b0, 32'h0, 33'h100000000);
    xact("cycle_rs_zero", 0, RS, 12'hC00, 32'h0, 1'b1, 1'b0, 32'h1234);
    xact("cycle_rs_ill", 0, RS, 12'hC00, 32'h1, 1'b0, 1'b1, 32'h0);
    xact("cycle_rw_ill", 0, RW, 12'hC00, 32'h0, 1'b1, 1'b1, 32'h0);
    xact("mcycle_kept", 0, RO, 12'hB00, 32'h0, 1'b0, 1'b0, 32'h1234);
    xact("unmapped", 0, RO, 12'h123, 32'h0, 1'b0, 1'b1, 32'h0);
    xact("mcycleh_zero", 0, RO, 12'hB80, 32'h0, 1'b0, 1'b0, 32'h0);

    // half writes without carry, then free-running carry into the high half
    xact("mcntinh_ir", 0, RW, 12'h320, 32'h4, 1'b0, 1'b0, 32'h5);
    xact("mcycle_lo_ff", 0, RW, 12'hB00, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h1234);
    xact("mcycle_hi_0", 0, RW, 12'hB80, 32'h0, 1'b0, 1'b0, 32'h0);
    xact("no_carry_lo", 0, RO, 12'hB00, 32'h0, 1'b0, 1'b0, 32'hFFFFFFFF);
    xact("carry_hi", 0, RO, 12'hB80, 32'h0, 1'b0, 1'b0, 32'h1);
    xact("carry_lo", 0, RO, 12'hB00, 32'h0, 1'b0, 1'b0, 32'h1);
    xact("cycleh_alias", 0, RO, 12'hC80, 32'h0, 1'b0, 1'b0, 32'h1);
    xact("minstret_set", 0, RW, 12'hB02, 32'h100, 1'b0, 1'b0, 32'h0);
    retire0 = 1'b1;
    xact("mcycle_set2", 0, RW, 12'hB00, 32'h1000, 1'b0, 1'b0, 32'h4);
    xact("mcycle_base", 0, RO, 12'hB00, 32'h0, 1'b0, 1'b0, 32'h1000);
    for (int i = 1; i < 10; i++)
      xact($sformatf("minstret_inh_%0d", i), 0, RO, 12'hB02, 32'h0, 1'b0, 1'b0, 32'h100);
    xact("mcycle_plus10", 0, RO, 12'hB00, 32'h0, 1'b0, 1'b0, 32'h100A);
    xact("minstret_held", 0, RO, 12'hB02, 32'h0, 1'b0, 1'b0, 32'h100);
    xact("minstreth", 0, RO, 12'hB82, 32'h0, 1'b0, 1'b0, 32'h0);
    xact("mcntinh_clr", 0, RW, 12'h320, 32'h0, 1'b0, 1'b0, 32'h4);
    xact("instret_100", 0, RO, 12'hC02, 32'h0, 1'b0, 1'b0, 32'h100);
    xact("instret_101", 0, RO, 12'hC02, 32'h0, 1'b0, 1'b0, 32'h101);
    retire0 = 1'b0;
    xact("instret_idle", 0, RO, 12'hC02, 32'h0, 1'b0, 1'b0, 32'h101);

    // no-FPU build with a 40-bit counter
    xact("nofpu_fflags", 1, RO, 12'h001, 32'h0, 1'b0, 1'b1, 32'h0);
    xact("nofpu_frm_wr", 1, RW, 12'h002, 32'h3, 1'b0, 1'b1, 32'h0);
    xact("nofpu_fcsr", 1, RW, 12'h003, 32'hE5, 1'b0, 1'b1, 32'h0);
    check("nofpu_frm", 64'(frm1), 64'h0);
    xact("w40_hi_set", 1, RW, 12'hB80, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h0);
    xact_m("w40_lo_set", 1, RW, 12'hB00, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h0, 33'h100000000);
    xact("w40_hi_pad", 1, RO, 12'hB80, 32'h0, 1'b0, 1'b0, 32'hFF);
    xact("w40_wrap_hi", 1, RO, 12'hB80, 32'h0, 1'b0, 1'b0, 32'h0);
    xact("w40_wrap_lo", 1, RO, 12'hB00, 32'h0, 1'b0, 1'b0, 32'h1);

    // asynchronous reset mid-count; a write during reset is dropped
    @(posedge clk);
    #1;
    bus1.i_csr_valid = 1'b0;
    bus0.i_csr_valid = 1'b1; bus0.i_csr_op = RO; bus0.i_csr_addr = 12'hB00;
    #2 rst_n = 1'b0;
    #1 check("rst_async_mcycle", 64'(bus0.o_rd_data), 64'h0);
    bus0.i_csr_addr = 12'hB02;
    #1 check("rst_async_minstret", 64'(bus0.o_rd_data), 64'h0);
    check("rst_async_frm", 64'(frm0), 64'h0);
    bus0.i_csr_op = RW; bus0.i_csr_addr = 12'h002; bus0.i_wr_data = 32'h3;
    @(posedge clk);
    @(posedge clk);
    #1 check("rst_write_dropped", 64'(frm0), 64'h0);
    rst_n = 1'b1;
    bus0.i_csr_op = RO;
    xact("post_rst_mcycle", 0, RO, 12'hB00, 32'h0, 1'b0, 1'b0, 32'h1);
    xact("post_rst_frm", 0, RO, 12'h002, 32'h0, 1'b0, 1'b0, 32'h0);
    xact("post_rst_fflags", 0, RO, 12'h001, 32'h0, 1'b0, 1'b0, 32'h0);
    xact("post_rst_inh", 0, RO, 12'h320, 32'h0, 1'b0, 1'b0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
